// File: rtl/icache_direct.sv
// Direct-mapped instruction cache, one 32-bit word per line.
// Hits reply one cycle after the request. A miss sends a single fetch pulse
// to memCtrl, waits for the word, fills the line and replies. A mispredict
// flush abandons an outstanding miss but leaves the cached lines valid.
module icache_direct #(
    parameter int INDEX_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        in_xbp,
    input  logic        in_fetch_valid,
    input  logic [31:0] in_fetch_pc,
    output logic        out_busy,
    output logic        out_inst_valid,
    output logic [31:0] out_inst,
    output logic [31:0] out_inst_pc,
    output logic        out_mem_flag,
    output logic [31:0] out_mem_addr,
    input  logic        in_mem_done,
    input  logic [31:0] in_mem_data
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 30 - INDEX_BITS;

    typedef enum logic {S_IDLE, S_MISS} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [LINES-1:0]      r_valid;
    logic [TAG_W-1:0]      r_tag  [LINES];
    logic [31:0]           r_data [LINES];
    logic [31:0]           r_req_pc;

    logic [INDEX_BITS-1:0] w_idx;
    logic [TAG_W-1:0]      w_tag;
    logic [INDEX_BITS-1:0] w_req_idx;
    logic [TAG_W-1:0]      w_req_tag;
    logic                  w_hit;
    logic                  w_fill;

    logic                  w_inst_valid_nxt;
    logic [31:0]           w_inst_nxt;
    logic [31:0]           w_inst_pc_nxt;
    logic                  w_mem_flag_nxt;
    logic [31:0]           w_mem_addr_nxt;
    logic [31:0]           w_req_pc_nxt;

    assign w_idx     = in_fetch_pc[INDEX_BITS+1:2];
    assign w_tag     = in_fetch_pc[31:INDEX_BITS+2];
    assign w_req_idx = r_req_pc[INDEX_BITS+1:2];
    assign w_req_tag = r_req_pc[31:INDEX_BITS+2];
    assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    // A return is only accepted while a miss is pending and no flush is in progress.
    assign w_fill    = (r_state == S_MISS) && in_mem_done && !in_xbp;
    assign out_busy  = (r_state == S_MISS);

    // Next-state and next-output decision; pulses default low, data outputs hold.
    always_comb begin
        w_state_nxt      = r_state;
        w_inst_valid_nxt = 1'b0;
        w_mem_flag_nxt   = 1'b0;
        w_inst_nxt       = out_inst;
        w_inst_pc_nxt    = out_inst_pc;
        w_mem_addr_nxt   = out_mem_addr;
        w_req_pc_nxt     = r_req_pc;
        if (in_xbp) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_fetch_valid) begin
                        w_req_pc_nxt = in_fetch_pc;
                        if (w_hit) begin
                            w_inst_valid_nxt = 1'b1;
                            w_inst_nxt       = r_data[w_idx];
                            w_inst_pc_nxt    = in_fetch_pc;
                        end else begin
                            w_mem_flag_nxt = 1'b1;
                            w_mem_addr_nxt = {in_fetch_pc[31:2], 2'b00};
                            w_state_nxt    = S_MISS;
                        end
                    end
                end
                S_MISS: begin
                    // Request pulse is not repeated here: memCtrl starts a read per sampled flag.
                    if (in_mem_done) begin
                        w_inst_valid_nxt = 1'b1;
                        w_inst_nxt       = in_mem_data;
                        w_inst_pc_nxt    = r_req_pc;
                        w_state_nxt      = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State, valid bits and output registers; everything holds while rdy is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_valid        <= '0;
            r_req_pc       <= '0;
            out_inst_valid <= 1'b0;
            out_inst       <= '0;
            out_inst_pc    <= '0;
            out_mem_flag   <= 1'b0;
            out_mem_addr   <= '0;
        end else if (rdy) begin
            r_state        <= w_state_nxt;
            r_req_pc       <= w_req_pc_nxt;
            out_inst_valid <= w_inst_valid_nxt;
            out_inst       <= w_inst_nxt;
            out_inst_pc    <= w_inst_pc_nxt;
            out_mem_flag   <= w_mem_flag_nxt;
            out_mem_addr   <= w_mem_addr_nxt;
            if (w_fill) begin
                r_valid[w_req_idx] <= 1'b1;
            end
        end
    end

    // Line fill of tag and data arrays; these arrays carry no reset.
    always_ff @(posedge clk) begin
        if (!rst && rdy && w_fill) begin
            r_tag[w_req_idx]  <= w_req_tag;
            r_data[w_req_idx] <= in_mem_data;
        end
    end
endmodule
